control_unit: RTL and testbench
===============================

CONTROL_UNIT -- requirements
Module: control_unit

Interface
REQ-001 Parameter: ALU_LAT, 2, ALU cycles spent in EXEC per instruction; legal range 1..15.
REQ-002 CLK  in  1  system clock, all state updates on rising edge.
REQ-003 RESET  in  1  asynchronous, active-high reset.
REQ-004 INSTR  in  32  instruction word: [31:24] opcode, [23:16] dest/offset, [15:8] src1, [7:0] src2/imm.
REQ-005 INSTR_VALID  in  1  INSTR holds a valid instruction.
REQ-006 INSTR_READY  out  1  unit accepts INSTR this cycle.
REQ-007 ZERO  in  1  ALU zero flag, sampled in COMMIT.
REQ-008 PC  out  32  program counter.
REQ-009 ALUOP  out  3  ALU SELECT code.
REQ-010 ALUSRC  out  1  1 = DATA2 from IMMEDIATE, 0 = from register.
REQ-011 NEGATE  out  1  1 = DATA2 two's-complemented before ALU.
REQ-012 IMMEDIATE  out  8  immediate operand.
REQ-013 READREG1, READREG2, WRITEREG  out  3 each  register file indices.
REQ-014 WRITEENABLE  out  1  register file write strobe.
REQ-015 ILLEGAL  out  1  one-cycle flag for an unknown opcode.

Function
REQ-016 The FSM SHALL have states FETCH, EXEC, and COMMIT; reset state is FETCH.
REQ-017 FETCH: INSTR_READY=1; INSTR_VALID=1 latches INSTR, moves to EXEC, and loads the counter with ALU_LAT-1; INSTR_VALID=0 holds FETCH and PC.
REQ-018 EXEC: counter decrements each cycle; counter==0 moves to COMMIT; INSTR_READY=0.
REQ-019 COMMIT: one cycle, always returns to FETCH; per-instruction period = ALU_LAT+2 cycles.
REQ-020 Decode outputs SHALL be registered from the latched instruction, valid from the first EXEC cycle, and held stable through COMMIT and the following FETCH.
REQ-021 Field mapping: READREG1=INSTR[10:8], READREG2=INSTR[2:0], WRITEREG=INSTR[18:16], IMMEDIATE=INSTR[7:0].
REQ-022 Opcode table (ALUOP/ALUSRC/NEGATE/writes):
  0x00 loadi 000/1/0/yes
  0x01 mov 000/0/0/yes
  0x02 add 001/0/0/yes
  0x03 sub 001/0/1/yes
  0x04 and 010/0/0/yes
  0x05 or 011/0/0/yes
  0x06 j 000/0/0/no
  0x07 beq 001/0/1/no
  0x08 bne 001/0/1/no
  0x09 ror 100/1/0/yes
REQ-023 WRITEENABLE SHALL pulse high for exactly the COMMIT cycle of write-type opcodes and be 0 otherwise.
REQ-024 PC SHALL update only at the end of COMMIT: default PC+4; target = PC+4+(sign-extended INSTR[23:16] << 2).
REQ-025 Target is taken for j unconditionally, for beq when ZERO=1, and for bne when ZERO=0 (ZERO sampled in COMMIT).
REQ-026 PC arithmetic SHALL be 32-bit modulo; 0xFFFFFFFC+4 wraps to 0x00000000.
REQ-027 Opcodes 0x0A-0xFF: ALUOP=000; ILLEGAL=1 and WRITEENABLE=0 in COMMIT; PC+4; no other side effect.
REQ-028 INSTR and INSTR_VALID SHALL be ignored outside FETCH.

Reset
REQ-029 RESET=1 SHALL immediately (no clock edge) force state FETCH, PC=0, ALUOP=0, ALUSRC=0, NEGATE=0, IMMEDIATE=0, READREG1/2=0, WRITEREG=0, WRITEENABLE=0, ILLEGAL=0, counter=0.
REQ-030 INSTR_READY SHALL be 0 while RESET=1 and 1 on the first cycle after RESET falls.
REQ-031 RESET asserted in EXEC or COMMIT SHALL abort the instruction with no write and no PC change beyond reset to 0.

Verification
REQ-032 Reset, then INSTR=0x00020005 valid -> EXEC shows ALUOP=000, ALUSRC=1, IMMEDIATE=0x05, WRITEREG=2; WRITEENABLE high in cycle 4 only; PC=4 after.
REQ-033 PC=0x08, beq 0x07FE0102 with ZERO=1 -> PC=0x04; repeat with ZERO=0 -> PC=0x0C; WRITEENABLE stays 0.
REQ-034 PC=0x10, j 0x06030000 -> PC=0x20; bne with ZERO=1 at PC=0x10 -> PC=0x14.
REQ-035 INSTR=0xFF000000 -> ILLEGAL one-cycle pulse in COMMIT, no WRITEENABLE, PC+4.
REQ-036 INSTR_VALID low 5 cycles -> INSTR_READY=1 and PC constant; then RESET pulse mid-EXEC of a sub -> all outputs 0 asynchronously, no write, PC=0.
REQ-037 ALU_LAT=1 and ALU_LAT=15 builds -> sub (0x03010203) period of 3 and 17 cycles respectively, NEGATE=1, ALUOP=001.

Source files
------------

// File: rtl/control_unit.sv
// control_unit: three-state sequencer (FETCH -> EXEC -> COMMIT) for a small
// 8-bit-operand CPU. It latches one instruction per pass, holds registered
// decode outputs for the ALU/register file, pulses the register write strobe
// in COMMIT and advances the PC (with relative branches) at the end of COMMIT.
// ALU_LAT sets the number of EXEC cycles; legal range is 1..15.
module control_unit #(
  parameter int unsigned ALU_LAT = 2
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic [31:0] INSTR,
  input  logic        INSTR_VALID,
  output logic        INSTR_READY,
  input  logic        ZERO,
  output logic [31:0] PC,
  output logic [2:0]  ALUOP,
  output logic        ALUSRC,
  output logic        NEGATE,
  output logic [7:0]  IMMEDIATE,
  output logic [2:0]  READREG1,
  output logic [2:0]  READREG2,
  output logic [2:0]  WRITEREG,
  output logic        WRITEENABLE,
  output logic        ILLEGAL
);

  typedef enum logic [1:0] {
    S_FETCH  = 2'd0,
    S_EXEC   = 2'd1,
    S_COMMIT = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    BR_NONE   = 2'd0,
    BR_ALWAYS = 2'd1,
    BR_EQ     = 2'd2,
    BR_NE     = 2'd3
  } branch_e;

  typedef struct packed {
    logic [2:0] aluop;
    logic       alusrc;
    logic       negate;
    logic       writes;
    logic       illegal;
    branch_e    branch;
  } decode_t;

  // EXEC lasts ALU_LAT cycles: the counter is loaded with ALU_LAT-1 and
  // COMMIT follows the cycle in which it reads zero.
  localparam logic [3:0] LAT_M1 = 4'(ALU_LAT - 1);

  // Opcode table; anything above 0x09 is illegal and behaves as a no-op.
  function automatic decode_t decode(input logic [7:0] op);
    decode_t d;
    d = '{aluop: 3'b000, alusrc: 1'b0, negate: 1'b0, writes: 1'b0,
          illegal: 1'b0, branch: BR_NONE};
    case (op)
      8'h00:   begin d.alusrc = 1'b1; d.writes = 1'b1; end                 // loadi
      8'h01:   d.writes = 1'b1;                                             // mov
      8'h02:   begin d.aluop = 3'b001; d.writes = 1'b1; end                 // add
      8'h03:   begin d.aluop = 3'b001; d.negate = 1'b1; d.writes = 1'b1; end // sub
      8'h04:   begin d.aluop = 3'b010; d.writes = 1'b1; end                 // and
      8'h05:   begin d.aluop = 3'b011; d.writes = 1'b1; end                 // or
      8'h06:   d.branch = BR_ALWAYS;                                        // j
      8'h07:   begin d.aluop = 3'b001; d.negate = 1'b1; d.branch = BR_EQ; end // beq
      8'h08:   begin d.aluop = 3'b001; d.negate = 1'b1; d.branch = BR_NE; end // bne
      8'h09:   begin d.aluop = 3'b100; d.alusrc = 1'b1; d.writes = 1'b1; end // ror
      default: d.illegal = 1'b1;
    endcase
    return d;
  endfunction

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] pc_q, pc_d;
  logic [2:0]  aluop_q, aluop_d;
  logic        alusrc_q, alusrc_d;
  logic        negate_q, negate_d;
  logic [7:0]  imm_q, imm_d;
  logic [2:0]  rr1_q, rr1_d;
  logic [2:0]  rr2_q, rr2_d;
  logic [2:0]  wr_q, wr_d;
  logic        writes_q, writes_d;
  logic        illegal_pend_q, illegal_pend_d;
  branch_e     branch_q, branch_d;
  logic [7:0]  offset_q, offset_d;
  logic        we_q, we_d;
  logic        ill_q, ill_d;

  decode_t     dec_in;
  logic        taken;
  logic [31:0] pc_plus4;
  logic [31:0] pc_target;
  logic        unused_instr_bits;

  assign dec_in            = decode(INSTR[31:24]);
  assign pc_plus4          = pc_q + 32'd4;
  assign pc_target         = pc_plus4 + {{22{offset_q[7]}}, offset_q, 2'b00};
  assign unused_instr_bits = ^INSTR[15:11];

  // Branch resolution uses ZERO as seen during COMMIT.
  always_comb begin
    case (branch_q)
      BR_ALWAYS: taken = 1'b1;
      BR_EQ:     taken = ZERO;
      BR_NE:     taken = ~ZERO;
      default:   taken = 1'b0;
    endcase
  end

  // Next-state logic: sequencing, instruction latch, strobes and PC update.
  always_comb begin
    // NOTE: every _d gets a default up front so no path through the case
    // leaves it unassigned, which would otherwise infer a latch.
    state_d        = state_q;
    cnt_d          = cnt_q;
    pc_d           = pc_q;
    aluop_d        = aluop_q;
    alusrc_d       = alusrc_q;
    negate_d       = negate_q;
    imm_d          = imm_q;
    rr1_d          = rr1_q;
    rr2_d          = rr2_q;
    wr_d           = wr_q;
    writes_d       = writes_q;
    illegal_pend_d = illegal_pend_q;
    branch_d       = branch_q;
    offset_d       = offset_q;
    we_d           = 1'b0;
    ill_d          = 1'b0;

    case (state_q)
      S_FETCH: begin
        if (INSTR_VALID) begin
          state_d        = S_EXEC;
          cnt_d          = LAT_M1;
          aluop_d        = dec_in.aluop;
          alusrc_d       = dec_in.alusrc;
          negate_d       = dec_in.negate;
          writes_d       = dec_in.writes;
          illegal_pend_d = dec_in.illegal;
          branch_d       = dec_in.branch;
          offset_d       = INSTR[23:16];
          imm_d          = INSTR[7:0];
          rr1_d          = INSTR[10:8];
          rr2_d          = INSTR[2:0];
          wr_d           = INSTR[18:16];
        end
      end
      S_EXEC: begin
        if (cnt_q == 4'd0) begin
          state_d = S_COMMIT;
          we_d    = writes_q;
          ill_d   = illegal_pend_q;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_COMMIT: begin
        state_d = S_FETCH;
        pc_d    = taken ? pc_target : pc_plus4;
      end
      default: state_d = S_FETCH;
    endcase
  end

  // State and output registers, cleared asynchronously by RESET.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q        <= S_FETCH;
      cnt_q          <= 4'd0;
      pc_q           <= 32'd0;
      aluop_q        <= 3'b000;
      alusrc_q       <= 1'b0;
      negate_q       <= 1'b0;
      imm_q          <= 8'd0;
      rr1_q          <= 3'd0;
      rr2_q          <= 3'd0;
      wr_q           <= 3'd0;
      writes_q       <= 1'b0;
      illegal_pend_q <= 1'b0;
      branch_q       <= BR_NONE;
      offset_q       <= 8'd0;
      we_q           <= 1'b0;
      ill_q          <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the
      // pre-edge value of the others, independent of statement order.
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      pc_q           <= pc_d;
      aluop_q        <= aluop_d;
      alusrc_q       <= alusrc_d;
      negate_q       <= negate_d;
      imm_q          <= imm_d;
      rr1_q          <= rr1_d;
      rr2_q          <= rr2_d;
      wr_q           <= wr_d;
      writes_q       <= writes_d;
      illegal_pend_q <= illegal_pend_d;
      branch_q       <= branch_d;
      offset_q       <= offset_d;
      we_q           <= we_d;
      ill_q          <= ill_d;
    end
  end

  // Ready is gated by RESET so it reads 0 for the whole reset interval.
  assign INSTR_READY = (state_q == S_FETCH) && !RESET;
  assign PC          = pc_q;
  assign ALUOP       = aluop_q;
  assign ALUSRC      = alusrc_q;
  assign NEGATE      = negate_q;
  assign IMMEDIATE   = imm_q;
  assign READREG1    = rr1_q;
  assign READREG2    = rr2_q;
  assign WRITEREG    = wr_q;
  assign WRITEENABLE = we_q;
  assign ILLEGAL     = ill_q;

endmodule

// File: tb/tb_control_unit.sv
// Directed self-checking bench for control_unit: a main instance at
// ALU_LAT=2 plus ALU_LAT=1 and ALU_LAT=15 instances for period checks.
module tb_control_unit;

  localparam int MAIN_LAT = 2;

  logic        CLK;
  logic        rst;
  logic [31:0] instr;
  logic        instr_valid;
  logic        zero;
  logic        ready;
  logic [31:0] pc;
  logic [2:0]  aluop;
  logic        alusrc, negate;
  logic [7:0]  imm;
  logic [2:0]  rr1, rr2, wr;
  logic        we, ill;

  logic        rst_b;
  logic [31:0] instr_b;
  logic        valid_b;
  logic        zero_b;
  logic        ready1, alusrc1, negate1, we1, ill1;
  logic [31:0] pc1;
  logic [2:0]  aluop1, rr11, rr21, wr1;
  logic [7:0]  imm1;
  logic        ready15, alusrc15, negate15, we15, ill15;
  logic [31:0] pc15;
  logic [2:0]  aluop15, rr115, rr215, wr15;
  logic [7:0]  imm15;

  int n_chk;
  int n_fail;

  logic [31:0] pc_model;

  // Snapshots captured by issue() at the first EXEC cycle, COMMIT, and the next FETCH.
  logic [2:0]  ex_aluop, ex_rr1, ex_rr2, ex_wr;
  logic        ex_alusrc, ex_neg, ex_we, ex_ready;
  logic [7:0]  ex_imm;
  logic        cm_we, cm_ill;
  logic [31:0] cm_pc;
  logic [31:0] af_pc;
  logic        af_we, af_ill, af_ready;
  logic [2:0]  af_aluop;

  control_unit #(.ALU_LAT(MAIN_LAT)) dut (
    .CLK(CLK), .RESET(rst), .INSTR(instr), .INSTR_VALID(instr_valid),
    .INSTR_READY(ready), .ZERO(zero), .PC(pc), .ALUOP(aluop), .ALUSRC(alusrc),
    .NEGATE(negate), .IMMEDIATE(imm), .READREG1(rr1), .READREG2(rr2),
    .WRITEREG(wr), .WRITEENABLE(we), .ILLEGAL(ill)
  );

  control_unit #(.ALU_LAT(1)) dut_lat1 (
    .CLK(CLK), .RESET(rst_b), .INSTR(instr_b), .INSTR_VALID(valid_b),
    .INSTR_READY(ready1), .ZERO(zero_b), .PC(pc1), .ALUOP(aluop1), .ALUSRC(alusrc1),
    .NEGATE(negate1), .IMMEDIATE(imm1), .READREG1(rr11), .READREG2(rr21),
    .WRITEREG(wr1), .WRITEENABLE(we1), .ILLEGAL(ill1)
  );

  control_unit #(.ALU_LAT(15)) dut_lat15 (
    .CLK(CLK), .RESET(rst_b), .INSTR(instr_b), .INSTR_VALID(valid_b),
    .INSTR_READY(ready15), .ZERO(zero_b), .PC(pc15), .ALUOP(aluop15), .ALUSRC(alusrc15),
    .NEGATE(negate15), .IMMEDIATE(imm15), .READREG1(rr115), .READREG2(rr215),
    .WRITEREG(wr15), .WRITEENABLE(we15), .ILLEGAL(ill15)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Drive one instruction from a FETCH cycle (called at posedge+1) and
  // capture outputs through EXEC, COMMIT and the following FETCH.
  task automatic issue(input logic [31:0] ins, input logic z);
    instr = ins; instr_valid = 1'b1; zero = z;
    @(posedge CLK); #1;
    ex_aluop = aluop; ex_alusrc = alusrc; ex_neg = negate; ex_imm = imm;
    ex_rr1 = rr1; ex_rr2 = rr2; ex_wr = wr; ex_we = we; ex_ready = ready;
    instr_valid = 1'b0; instr = 32'hDEAD_BEEF;
    for (int i = 1; i < MAIN_LAT; i++) begin
      @(posedge CLK); #1;
      ex_we = ex_we | we;
    end
    @(posedge CLK); #1;
    cm_we = we; cm_ill = ill; cm_pc = pc;
    @(posedge CLK); #1;
    af_pc = pc; af_we = we; af_ill = ill; af_ready = ready; af_aluop = aluop;
  endtask

  task automatic test_reset();
    rst = 1'b1; instr = 32'h0; instr_valid = 1'b0; zero = 1'b0;
    rst_b = 1'b1; instr_b = 32'h0; valid_b = 1'b0; zero_b = 1'b0;
    #2;
    n_chk++; if ({pc, aluop, alusrc, negate, imm, rr1, rr2, wr, we, ill} !== '0) begin
      n_fail++; $display("FAIL reset_outputs: got pc=%h aluop=%b we=%b ill=%b expected all zero", pc, aluop, we, ill); end
    n_chk++; if (ready !== 1'b0) begin n_fail++; $display("FAIL reset_ready: got %b expected 0", ready); end
    #10; rst = 1'b0; #1;
    n_chk++; if (ready !== 1'b1) begin n_fail++; $display("FAIL ready_after_reset: got %b expected 1", ready); end
    @(posedge CLK); #1;
    pc_model = 32'h0;
  endtask

  task automatic test_loadi();
    issue(32'h0002_0005, 1'b0);
    n_chk++; if (ex_aluop !== 3'b000) begin n_fail++; $display("FAIL loadi_aluop: got %b expected 000", ex_aluop); end
    n_chk++; if (ex_alusrc !== 1'b1) begin n_fail++; $display("FAIL loadi_alusrc: got %b expected 1", ex_alusrc); end
    n_chk++; if (ex_imm !== 8'h05) begin n_fail++; $display("FAIL loadi_imm: got %h expected 05", ex_imm); end
    n_chk++; if (ex_wr !== 3'd2) begin n_fail++; $display("FAIL loadi_writereg: got %0d expected 2", ex_wr); end
    n_chk++; if (ex_ready !== 1'b0) begin n_fail++; $display("FAIL loadi_exec_ready: got %b expected 0", ex_ready); end
    n_chk++; if (ex_we !== 1'b0) begin n_fail++; $display("FAIL loadi_exec_we: got %b expected 0", ex_we); end
    n_chk++; if (cm_we !== 1'b1) begin n_fail++; $display("FAIL loadi_commit_we: got %b expected 1", cm_we); end
    n_chk++; if (cm_pc !== 32'h0) begin n_fail++; $display("FAIL loadi_commit_pc: got %h expected 0", cm_pc); end
    n_chk++; if (af_we !== 1'b0) begin n_fail++; $display("FAIL loadi_after_we: got %b expected 0", af_we); end
    n_chk++; if (af_pc !== 32'h4) begin n_fail++; $display("FAIL loadi_pc: got %h expected 4", af_pc); end
    n_chk++; if (af_ready !== 1'b1) begin n_fail++; $display("FAIL loadi_after_ready: got %b expected 1", af_ready); end
    n_chk++; if (af_aluop !== 3'b000 || ex_rr2 !== 3'd5) begin n_fail++; $display("FAIL loadi_hold: got aluop=%b rr2=%0d expected 000/5", af_aluop, ex_rr2); end
    pc_model = 32'h4;
  endtask

  task automatic test_branches();
    issue(32'h0600_0000, 1'b0);            // j +0 : 4 -> 8
    n_chk++; if (af_pc !== 32'h8) begin n_fail++; $display("FAIL j0_pc: got %h expected 8", af_pc); end
    issue(32'h07FE_0102, 1'b1);            // beq taken: 8+4-8
    n_chk++; if (af_pc !== 32'h4) begin n_fail++; $display("FAIL beq_taken_pc: got %h expected 4", af_pc); end
    n_chk++; if (cm_we !== 1'b0 || ex_we !== 1'b0) begin n_fail++; $display("FAIL beq_we: got %b expected 0", cm_we | ex_we); end
    n_chk++; if ({ex_aluop, ex_alusrc, ex_neg} !== 5'b001_0_1) begin n_fail++; $display("FAIL beq_decode: got %b expected 00101", {ex_aluop, ex_alusrc, ex_neg}); end
    n_chk++; if ({ex_rr1, ex_rr2, ex_wr} !== {3'd1, 3'd2, 3'd6}) begin n_fail++; $display("FAIL beq_fields: got %0d/%0d/%0d expected 1/2/6", ex_rr1, ex_rr2, ex_wr); end
    issue(32'h0600_0000, 1'b0);            // back to 8
    issue(32'h07FE_0102, 1'b0);            // beq not taken
    n_chk++; if (af_pc !== 32'hC) begin n_fail++; $display("FAIL beq_not_taken_pc: got %h expected C", af_pc); end
    n_chk++; if (cm_we !== 1'b0) begin n_fail++; $display("FAIL beq_nt_we: got %b expected 0", cm_we); end
    issue(32'h0103_0405, 1'b0);            // mov: C -> 10
    n_chk++; if (af_pc !== 32'h10 || cm_we !== 1'b1) begin n_fail++; $display("FAIL mov_pc_we: got pc=%h we=%b expected 10/1", af_pc, cm_we); end
    issue(32'h0603_0000, 1'b0);            // j +3 : 10+4+12
    n_chk++; if (af_pc !== 32'h20) begin n_fail++; $display("FAIL j3_pc: got %h expected 20", af_pc); end
    issue(32'h06FB_0000, 1'b0);            // j -5 : 20+4-20
    n_chk++; if (af_pc !== 32'h10) begin n_fail++; $display("FAIL j_neg_pc: got %h expected 10", af_pc); end
    issue(32'h0801_0000, 1'b1);            // bne with ZERO=1 not taken
    n_chk++; if (af_pc !== 32'h14) begin n_fail++; $display("FAIL bne_nt_pc: got %h expected 14", af_pc); end
    issue(32'h0801_0000, 1'b0);            // bne with ZERO=0 taken: 14+4+4
    n_chk++; if (af_pc !== 32'h1C) begin n_fail++; $display("FAIL bne_taken_pc: got %h expected 1C", af_pc); end
    pc_model = 32'h1C;
  endtask

  task automatic test_illegal();
    issue(32'hFF00_0000, 1'b0);
    n_chk++; if (cm_ill !== 1'b1) begin n_fail++; $display("FAIL illegal_commit: got %b expected 1", cm_ill); end
    n_chk++; if (af_ill !== 1'b0) begin n_fail++; $display("FAIL illegal_pulse_width: got %b expected 0", af_ill); end
    n_chk++; if (cm_we !== 1'b0 || ex_aluop !== 3'b000) begin n_fail++; $display("FAIL illegal_we_aluop: got we=%b aluop=%b expected 0/000", cm_we, ex_aluop); end
    n_chk++; if (af_pc !== pc_model + 32'd4) begin n_fail++; $display("FAIL illegal_pc: got %h expected %h", af_pc, pc_model + 32'd4); end
    pc_model = pc_model + 32'd4;
  endtask

  task automatic test_decode_table();
    logic [7:0] ops [8]  = '{8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h09, 8'h0A};
    logic [6:0] exp [8]  = '{7'b000_1_0_1_0, 7'b000_0_0_1_0, 7'b001_0_0_1_0, 7'b001_0_1_1_0,
                             7'b010_0_0_1_0, 7'b011_0_0_1_0, 7'b100_1_0_1_0, 7'b000_0_0_0_1};
    for (int i = 0; i < 8; i++) begin
      issue({ops[i], 24'h05_3A_C7}, 1'b0);
      n_chk++; if ({ex_aluop, ex_alusrc, ex_neg, cm_we, cm_ill} !== exp[i]) begin
        n_fail++; $display("FAIL decode_op%h: got %b expected %b", ops[i], {ex_aluop, ex_alusrc, ex_neg, cm_we, cm_ill}, exp[i]); end
      n_chk++; if ({ex_rr1, ex_rr2, ex_wr, ex_imm} !== {3'd2, 3'd7, 3'd5, 8'hC7}) begin
        n_fail++; $display("FAIL fields_op%h: got %0d/%0d/%0d/%h expected 2/7/5/c7", ops[i], ex_rr1, ex_rr2, ex_wr, ex_imm); end
      n_chk++; if (af_pc !== pc_model + 32'd4) begin n_fail++; $display("FAIL pc_op%h: got %h expected %h", ops[i], af_pc, pc_model + 32'd4); end
      pc_model = pc_model + 32'd4;
    end
  endtask

  task automatic test_idle_then_reset();
    instr_valid = 1'b0; instr = 32'h0200_0000;
    for (int i = 0; i < 5; i++) begin
      @(posedge CLK); #1;
      n_chk++; if (ready !== 1'b1 || pc !== pc_model) begin
        n_fail++; $display("FAIL idle_%0d: got ready=%b pc=%h expected 1/%h", i, ready, pc, pc_model); end
    end
    instr = 32'h0301_0203; instr_valid = 1'b1;
    @(posedge CLK); #1;
    instr_valid = 1'b0;
    n_chk++; if (negate !== 1'b1 || aluop !== 3'b001) begin n_fail++; $display("FAIL sub_exec: got neg=%b aluop=%b expected 1/001", negate, aluop); end
    rst = 1'b1; #1;
    n_chk++; if ({pc, aluop, alusrc, negate, imm, rr1, rr2, wr, we, ill, ready} !== '0) begin
      n_fail++; $display("FAIL async_reset: got pc=%h aluop=%b neg=%b imm=%h ready=%b expected all zero", pc, aluop, negate, imm, ready); end
    @(posedge CLK); #1;
    n_chk++; if (we !== 1'b0 || pc !== 32'h0 || ready !== 1'b0) begin n_fail++; $display("FAIL reset_held: got we=%b pc=%h ready=%b expected 0/0/0", we, pc, ready); end
    #2; rst = 1'b0; #1;
    n_chk++; if (ready !== 1'b1) begin n_fail++; $display("FAIL ready_after_abort: got %b expected 1", ready); end
    for (int i = 0; i < 3; i++) begin
      @(posedge CLK); #1;
      n_chk++; if (we !== 1'b0 || pc !== 32'h0) begin n_fail++; $display("FAIL abort_%0d: got we=%b pc=%h expected 0/0", i, we, pc); end
    end
    pc_model = 32'h0;
  endtask

  task automatic test_pc_wrap();
    issue(32'h06FE_0000, 1'b0);            // 0+4-8 = FFFFFFFC
    n_chk++; if (af_pc !== 32'hFFFF_FFFC) begin n_fail++; $display("FAIL wrap_setup_pc: got %h expected fffffffc", af_pc); end
    issue(32'h0203_0102, 1'b0);            // add: wraps to 0
    n_chk++; if (af_pc !== 32'h0) begin n_fail++; $display("FAIL wrap_pc: got %h expected 0", af_pc); end
    n_chk++; if (cm_we !== 1'b1) begin n_fail++; $display("FAIL wrap_add_we: got %b expected 1", cm_we); end
  endtask

  task automatic test_alu_latency();
    int r1 [2];
    int r15 [2];
    int n1, n15;
    logic [3:0] d1, d15;
    logic we1_c1, we1_c2, we15_c15, we15_c16;
    r1 = '{-1, -1}; r15 = '{-1, -1}; n1 = 0; n15 = 0;
    d1 = '0; d15 = '0; we1_c1 = 1'bx; we1_c2 = 1'bx; we15_c15 = 1'bx; we15_c16 = 1'bx;
    instr_b = 32'h0301_0203; valid_b = 1'b1;
    @(posedge CLK); #1;
    rst_b = 1'b0;
    for (int c = 0; c < 60; c++) begin
      if (ready1 === 1'b1 && n1 < 2) begin r1[n1] = c; n1++; end
      if (ready15 === 1'b1 && n15 < 2) begin r15[n15] = c; n15++; end
      if (c == 1) begin d1 = {aluop1, negate1}; d15 = {aluop15, negate15}; we1_c1 = we1; end
      if (c == 2) we1_c2 = we1;
      if (c == 15) we15_c15 = we15;
      if (c == 16) we15_c16 = we15;
      @(posedge CLK); #1;
    end
    valid_b = 1'b0;
    n_chk++; if (r1[1] - r1[0] != 3) begin n_fail++; $display("FAIL lat1_period: got %0d expected 3", r1[1] - r1[0]); end
    n_chk++; if (r15[1] - r15[0] != 17) begin n_fail++; $display("FAIL lat15_period: got %0d expected 17", r15[1] - r15[0]); end
    n_chk++; if (d1 !== 4'b001_1 || d15 !== 4'b001_1) begin n_fail++; $display("FAIL lat_decode: got %b/%b expected 0011", d1, d15); end
    n_chk++; if (we1_c1 !== 1'b0 || we1_c2 !== 1'b1) begin n_fail++; $display("FAIL lat1_we: got %b%b expected 01", we1_c1, we1_c2); end
    n_chk++; if (we15_c15 !== 1'b0 || we15_c16 !== 1'b1) begin n_fail++; $display("FAIL lat15_we: got %b%b expected 01", we15_c15, we15_c16); end
  endtask

  initial begin
    n_chk = 0; n_fail = 0;
    test_reset();
    test_loadi();
    test_branches();
    test_illegal();
    test_decode_table();
    test_idle_then_reset();
    test_pc_wrap();
    test_alu_latency();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
